// File: rtl/timer0_pkg.sv
// Shared SFR addresses, TMOD mode encodings and small helpers for the 8051 timer 0/1 core.
package timer0_pkg;

  localparam logic [7:0] SFR_TL0 = 8'h8A;
  localparam logic [7:0] SFR_TH0 = 8'h8C;

  typedef enum logic [1:0] {
    TMODE_13BIT  = 2'b00,
    TMODE_16BIT  = 2'b01,
    TMODE_RELOAD = 2'b10,
    TMODE_SPLIT  = 2'b11
  } tmode_e;

  // Field view of the low TMOD nibble: {GATE, C/T, M1, M0}.
  typedef struct packed {
    logic   gate;
    logic   c_t;
    tmode_e mode;
  } tmod_t;

  // TL0/TH0 are not bit-addressable, so only plain byte writes load them.
  function automatic logic byte_write(input logic       wr_en,
                                      input logic       wr_bit_en,
                                      input logic [7:0] addr,
                                      input logic [7:0] target);
    return wr_en & ~wr_bit_en & (addr == target);
  endfunction

endpackage

// File: rtl/timer0_unit_pin_sync_edge.sv
// Two-flop synchronizer for an asynchronous pin plus a falling-edge detector
// that samples the synchronized level once per machine cycle.
module pin_sync_edge #(
  parameter bit DETECT_FALL = 1'b1
) (
  input  logic clock,
  input  logic reset,
  input  logic pin,
  input  logic cycle_en,
  output logic sig
);

  logic sync_meta;
  logic sync_q;
  logic sample_q;

  // NOTE: reset to 1 so an idle-high pin never looks like a falling edge
  // on the first machine cycle after reset is released.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync_meta <= 1'b1;
      sync_q    <= 1'b1;
      sample_q  <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments make each flop capture the value its
      // predecessor held before this edge, giving a true two-stage shift.
      sync_meta <= pin;
      sync_q    <= sync_meta;
      if (cycle_en) sample_q <= sync_q;
    end
  end

  // Edge mode: one-clock pulse on the cycle_en tick where the sampled level
  // drops from 1 to 0. Level mode: plain synchronized pin.
  assign sig = DETECT_FALL ? (cycle_en & sample_q & ~sync_q) : sync_q;

endmodule

// File: rtl/timer0_unit.sv
// Timer/counter 0 core: owns TL0/TH0, counts per TMOD modes 0-3, raises the
// TF0/TF1 set pulses and drives SFR read-back for its two addresses.
module timer0_unit
  import timer0_pkg::*;
#(
  parameter logic [7:0] TL_ADDR = SFR_TL0,
  parameter logic [7:0] TH_ADDR = SFR_TH0
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] data_in,
  input  logic [7:0] addr,
  input  logic       wr_en,
  input  logic       wr_bit_en,
  input  logic       cycle_en,
  input  logic [3:0] tmod_t0,
  input  logic       tr0,
  input  logic       tr1,
  input  logic       int0_n,
  input  logic       t0_pin,
  output logic [7:0] data_out,
  output logic       sfr_hit,
  output logic       tf0_set,
  output logic       tf1_set
);

  tmod_t      tmod;
  logic [7:0] tl;
  logic [7:0] th;
  logic [7:0] tl_nxt;
  logic [7:0] th_nxt;
  logic       tf0_nxt;
  logic       tf1_nxt;
  logic       int0_sync;
  logic       t0_fall;
  logic       run0;
  logic       tick0;
  logic       tick1;
  logic       wr_tl;
  logic       wr_th;
  logic [5:0] lo5_sum;

  assign tmod = tmod_t0;

  pin_sync_edge #(.DETECT_FALL(1'b1)) u_t0_sync (
    .clock    (clock),
    .reset    (reset),
    .pin      (t0_pin),
    .cycle_en (cycle_en),
    .sig      (t0_fall)
  );

  pin_sync_edge #(.DETECT_FALL(1'b0)) u_int0_sync (
    .clock    (clock),
    .reset    (reset),
    .pin      (int0_n),
    .cycle_en (cycle_en),
    .sig      (int0_sync)
  );

  assign run0  = tr0 & (~tmod.gate | int0_sync);
  assign tick0 = run0 & (tmod.c_t ? t0_fall : cycle_en);
  // Mode 3 borrows timer 1's run bit for TH0, which always counts machine cycles.
  assign tick1 = cycle_en & tr1;

  assign wr_tl = byte_write(wr_en, wr_bit_en, addr, TL_ADDR);
  assign wr_th = byte_write(wr_en, wr_bit_en, addr, TH_ADDR);

  // Mode 0 prescaler: TL[4:0] plus one, bit 5 is the carry into TH.
  assign lo5_sum = {1'b0, tl[4:0]} + 6'd1;

  // A written byte neither counts nor overflows; a carry out of a written TL
  // never reaches TH, and a carry into a written TH is dropped.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave one unassigned and infer a latch.
    tl_nxt  = tl;
    th_nxt  = th;
    tf0_nxt = 1'b0;
    tf1_nxt = 1'b0;
    case (tmod.mode)
      TMODE_13BIT: begin
        if (tick0 && !wr_tl) begin
          tl_nxt[4:0] = lo5_sum[4:0];
          if (lo5_sum[5] && !wr_th) begin
            th_nxt  = th + 8'd1;
            tf0_nxt = (th == 8'hFF);
          end
        end
      end
      TMODE_16BIT: begin
        if (tick0 && !wr_tl) begin
          tl_nxt = tl + 8'd1;
          if (tl == 8'hFF && !wr_th) begin
            th_nxt  = th + 8'd1;
            tf0_nxt = (th == 8'hFF);
          end
        end
      end
      TMODE_RELOAD: begin
        // Reload uses the TH value held before this edge, even if TH is being written.
        if (tick0 && !wr_tl) begin
          if (tl == 8'hFF) begin
            tl_nxt  = th;
            tf0_nxt = 1'b1;
          end else begin
            tl_nxt = tl + 8'd1;
          end
        end
      end
      TMODE_SPLIT: begin
        if (tick0 && !wr_tl) begin
          tl_nxt  = tl + 8'd1;
          tf0_nxt = (tl == 8'hFF);
        end
        if (tick1 && !wr_th) begin
          th_nxt  = th + 8'd1;
          tf1_nxt = (th == 8'hFF);
        end
      end
      default: ;
    endcase
    if (wr_tl) tl_nxt = data_in;
    if (wr_th) th_nxt = data_in;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      tl      <= 8'h00;
      th      <= 8'h00;
      tf0_set <= 1'b0;
      tf1_set <= 1'b0;
    end else begin
      tl      <= tl_nxt;
      th      <= th_nxt;
      tf0_set <= tf0_nxt;
      tf1_set <= tf1_nxt;
    end
  end

  assign sfr_hit  = (addr == TL_ADDR) || (addr == TH_ADDR);
  assign data_out = (addr == TL_ADDR) ? tl :
                    (addr == TH_ADDR) ? th : 8'h00;

endmodule
